// File: rtl/full_adder_pkg.sv
// Shared constants for the ripple-carry full adder.
package full_adder_pkg;

    localparam int FA_DEFAULT_WIDTH = 1;
    localparam int FA_MAX_WIDTH     = 64;

endpackage

// File: rtl/full_adder_cell.sv
// One-bit full adder cell; the building block of the ripple chain.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic p;

    assign p    = a ^ b;
    assign sum  = p ^ cin;
    assign cout = (a & b) | (cin & p);

endmodule

// File: rtl/full_adder.sv
// WIDTH-bit ripple-carry adder with signed-overflow flag and an optional
// registered output stage (synchronous active-high reset).
module full_adder
    import full_adder_pkg::*;
#(
    parameter int WIDTH      = FA_DEFAULT_WIDTH,
    parameter bit REGISTERED = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    if (WIDTH < 1 || WIDTH > FA_MAX_WIDTH) begin : g_bad_width
        $error("full_adder: WIDTH %0d outside legal range 1..%0d", WIDTH, FA_MAX_WIDTH);
    end

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_d;
    logic             cout_d;
    logic             ovf_d;

    assign carry[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        full_adder_cell u_cell (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (carry[i]),
            .sum  (sum_d[i]),
            .cout (carry[i+1])
        );
    end

    // Carry into the MSB differs from carry out exactly on signed overflow.
    assign cout_d = carry[WIDTH];
    assign ovf_d  = carry[WIDTH] ^ carry[WIDTH-1];

    if (REGISTERED) begin : g_reg
        logic [WIDTH-1:0] sum_q;
        logic             cout_q;
        logic             ovf_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                sum_q  <= '0;
                cout_q <= 1'b0;
                ovf_q  <= 1'b0;
            end else begin
                sum_q  <= sum_d;
                cout_q <= cout_d;
                ovf_q  <= ovf_d;
            end
        end

        assign sum  = sum_q;
        assign cout = cout_q;
        assign ovf  = ovf_q;
    end else begin : g_comb
        // Clock and reset are intentionally ignored in the combinational build.
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst;

        assign sum  = sum_d;
        assign cout = cout_d;
        assign ovf  = ovf_d;
    end

endmodule

// File: tb/tb_full_adder.sv
// Self-checking bench: truth table, registered-stage sequences, random vs model.
module tb_full_adder;

    int checks = 0;
    int errors = 0;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // WIDTH=1 combinational, clk/rst connected (and wiggled)
    logic       a1, b1, cin1;
    logic       s1, co1, ov1;
    // WIDTH=1 combinational, clk/rst left floating
    logic       s1n, co1n, ov1n;
    // WIDTH=4 registered
    logic [3:0] a4, b4;
    logic       cin4;
    logic [3:0] s4;
    logic       co4, ov4;
    // WIDTH=8 combinational
    logic [7:0] a8, b8;
    logic       cin8;
    logic [7:0] s8;
    logic       co8, ov8;

    full_adder #(.WIDTH(1), .REGISTERED(1'b0)) u_w1 (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .cin(cin1),
        .sum(s1), .cout(co1), .ovf(ov1)
    );

    full_adder #(.WIDTH(1), .REGISTERED(1'b0)) u_w1_nc (
        .clk(1'bz), .rst(1'bz), .a(a1), .b(b1), .cin(cin1),
        .sum(s1n), .cout(co1n), .ovf(ov1n)
    );

    full_adder #(.WIDTH(4), .REGISTERED(1'b1)) u_w4 (
        .clk(clk), .rst(rst), .a(a4), .b(b4), .cin(cin4),
        .sum(s4), .cout(co4), .ovf(ov4)
    );

    full_adder #(.WIDTH(8), .REGISTERED(1'b0)) u_w8 (
        .clk(clk), .rst(rst), .a(a8), .b(b8), .cin(cin8),
        .sum(s8), .cout(co8), .ovf(ov8)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic a, b, cin;
        logic cout, sum, ovf;
    } vec1_t;

    vec1_t tbl[8];

    // Reference model: plain integer arithmetic on the operands.
    function automatic logic [4:0] ref4(input logic [3:0] a, input logic [3:0] b, input logic c);
        return 5'(int'(a) + int'(b) + int'(c));
    endfunction

    function automatic logic sovf(input int sa, input int sb, input int c, input int w);
        int s;
        s = sa + sb + c;
        return (s > (2 ** (w - 1)) - 1) || (s < -(2 ** (w - 1)));
    endfunction

    task automatic check_w4(input string name, input logic [3:0] es, input logic ec, input logic eo);
        check({name, ".sum"},  64'(s4),  64'(es));
        check({name, ".cout"}, 64'(co4), 64'(ec));
        check({name, ".ovf"},  64'(ov4), 64'(eo));
    endtask

    initial begin
        logic [4:0] r4;
        logic [8:0] r8;
        logic [3:0] pa, pb;
        logic       pc;

        tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

        a1 = 0; b1 = 0; cin1 = 0;
        a4 = 0; b4 = 0; cin4 = 0;
        a8 = 0; b8 = 0; cin8 = 0;

        // WIDTH=1 truth table, 5-unit spacing; rst toggled to show it is ignored
        for (int i = 0; i < 8; i++) begin
            a1 = tbl[i].a; b1 = tbl[i].b; cin1 = tbl[i].cin;
            rst = i[0];
            #2;
            check($sformatf("w1[%0d].sum", i),  64'(s1),   64'(tbl[i].sum));
            check($sformatf("w1[%0d].cout", i), 64'(co1),  64'(tbl[i].cout));
            check($sformatf("w1[%0d].ovf", i),  64'(ov1),  64'(tbl[i].ovf));
            check($sformatf("w1nc[%0d].sum", i),  64'(s1n),  64'(tbl[i].sum));
            check($sformatf("w1nc[%0d].cout", i), 64'(co1n), 64'(tbl[i].cout));
            check($sformatf("w1nc[%0d].ovf", i),  64'(ov1n), 64'(tbl[i].ovf));
            #3;
        end

        // WIDTH=4 registered: reset state
        @(negedge clk);
        rst = 1'b1; a4 = 4'h5; b4 = 4'h6; cin4 = 1'b1;
        @(negedge clk);
        check_w4("w4.reset", 4'h0, 1'b0, 1'b0);

        // first edge after reset release captures current inputs
        rst = 1'b0; a4 = 4'h3; b4 = 4'h4; cin4 = 1'b0;
        @(negedge clk);
        check_w4("w4.first", 4'h7, 1'b0, 1'b0);

        // F+1: prior value held until the edge, then wraps
        a4 = 4'hF; b4 = 4'h1; cin4 = 1'b0;
        #1 check_w4("w4.pre_edge", 4'h7, 1'b0, 1'b0);
        @(negedge clk);
        check_w4("w4.F+1", 4'h0, 1'b1, 1'b0);

        // 7+1 signed overflow; inputs wiggle before the edge without effect
        a4 = 4'h7; b4 = 4'h1; cin4 = 1'b0;
        #1 check_w4("w4.hold_a", 4'h0, 1'b1, 1'b0);
        a4 = 4'h2; b4 = 4'h9; #1;
        check_w4("w4.hold_b", 4'h0, 1'b1, 1'b0);
        a4 = 4'h7; b4 = 4'h1;
        @(negedge clk);
        check_w4("w4.7+1", 4'h8, 1'b0, 1'b1);

        // wrap-around all-ones + zero + cin
        a4 = 4'hF; b4 = 4'h0; cin4 = 1'b1;
        @(negedge clk);
        check_w4("w4.wrap", 4'h0, 1'b1, 1'b0);

        // mid-stream reset discards F+F+1, next edge captures it
        rst = 1'b1; a4 = 4'hF; b4 = 4'hF; cin4 = 1'b1;
        @(negedge clk);
        check_w4("w4.rst_mid", 4'h0, 1'b0, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check_w4("w4.after_rst", 4'hF, 1'b1, 1'b0);

        // WIDTH=4 registered random: output reflects inputs before last edge
        for (int i = 0; i < 50; i++) begin
            pa = 4'($urandom); pb = 4'($urandom); pc = 1'($urandom);
            a4 = pa; b4 = pb; cin4 = pc;
            @(negedge clk);
            a4 = 4'($urandom); b4 = 4'($urandom);
            r4 = ref4(pa, pb, pc);
            #1 check_w4($sformatf("w4.rnd%0d", i), r4[3:0], r4[4],
                        sovf(int'($signed(pa)), int'($signed(pb)), int'(pc), 4));
        end

        // WIDTH=8 combinational random vs arithmetic reference
        for (int i = 0; i < 1000; i++) begin
            a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
            #1;
            r8 = 9'(int'(a8) + int'(b8) + int'(cin8));
            check($sformatf("w8[%0d].sum", i), 64'({co8, s8}), 64'(r8));
            check($sformatf("w8[%0d].ovf", i), 64'(ov8),
                  64'(sovf(int'($signed(a8)), int'($signed(b8)), int'(cin8), 8)));
        end

        // WIDTH=8 boundary patterns
        a8 = 8'hFF; b8 = 8'h00; cin8 = 1'b1; #1;
        check("w8.wrap", 64'({co8, s8, ov8}), 64'({1'b1, 8'h00, 1'b0}));
        a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0; #1;
        check("w8.negovf", 64'({co8, s8, ov8}), 64'({1'b1, 8'h00, 1'b1}));
        a8 = 8'h7F; b8 = 8'h00; cin8 = 1'b1; #1;
        check("w8.posovf", 64'({co8, s8, ov8}), 64'({1'b0, 8'h80, 1'b1}));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/full_adder.md
FULL_ADDER -- requirements
Module: full_adder

Interface
REQ-001 Parameter WIDTH, default 1: operand width in bits; legal range 1..64.
REQ-002 Parameter REGISTERED, default 0: 0 = purely combinational outputs; 1 = one registered output stage.
REQ-003 Port clk  input  1  sole clock, rising-edge; used only when REGISTERED=1.
REQ-004 Port rst  input  1  reset, synchronous and active-high; used only when REGISTERED=1.
REQ-005 Port a  input  WIDTH  addend A, unsigned or two's complement.
REQ-006 Port b  input  WIDTH  addend B.
REQ-007 Port cin  input  1  carry-in to bit 0.
REQ-008 Port sum  output  WIDTH  sum bits.
REQ-009 Port cout  output  1  carry-out of MSB.
REQ-010 Port ovf  output  1  signed overflow flag, carry into MSB XOR carry out of MSB.

Function
REQ-011 {cout, sum} SHALL equal a + b + cin, computed at width WIDTH+1, with no truncation beyond WIDTH+1 bits.
REQ-012 For WIDTH=1: sum SHALL be a XOR b XOR cin, and cout SHALL be (a AND b) OR (cin AND (a XOR b)).
REQ-013 The adder SHALL be a ripple-carry chain of WIDTH one-bit cells, with the carry of cell i driving cell i+1.
REQ-014 ovf SHALL be 1 exactly when a and b have equal MSBs and sum's MSB differs from them; for WIDTH=1, ovf = cin XOR cout.
REQ-015 REGISTERED=0: sum, cout and ovf SHALL settle combinationally with zero clock latency, and SHALL be independent of clk and rst, including when those ports are unconnected.
REQ-016 REGISTERED=1: sum, cout and ovf SHALL be captured on each rising clk edge, giving 1-cycle latency from input change to output.
REQ-017 REGISTERED=1: outputs SHALL hold their value between edges regardless of input activity.
REQ-018 Wrap-around: all-ones + all-zeros + cin=1 SHALL produce sum=0 and cout=1.
REQ-019 Any X or Z on an input SHALL propagate only to the affected bits and their carry chain; the adder SHALL NOT mask X.

Reset
REQ-020 REGISTERED=1: on a rising clk edge with rst=1, sum SHALL become 0, cout 0 and ovf 0, overriding the inputs.
REQ-021 Reset asserted mid-stream SHALL discard the result being captured on that edge.
REQ-022 The first edge after rst deasserts SHALL capture the current inputs.
REQ-023 REGISTERED=0: rst SHALL have no effect.
REQ-024 No asynchronous reset path SHALL exist.

Structure
REQ-025 A shared package SHALL hold the default WIDTH constant and a helper constant for the maximum WIDTH (64).
REQ-026 A single sub-module, full_adder_cell (1-bit a, b, cin -> sum, cout), SHALL be instantiated WIDTH times via a generate loop.
REQ-027 The optional output register SHALL be a generate-selected block in full_adder itself, not a separate module.
REQ-028 An elaboration-time check SHALL reject WIDTH<1 or WIDTH>64.

Verification
REQ-029 WIDTH=1, REGISTERED=0, exhaustive 8 combinations of a,b,cin at 5-time-unit spacing:
- 000->cout=0,sum=0
- 100->01
- 010->01
- 110->10
- 001->01
- 101->10
- 011->10
- 111->11
REQ-030 WIDTH=1, REGISTERED=0, clk/rst left unconnected: outputs SHALL match REQ-029 with no X.
REQ-031 WIDTH=4, REGISTERED=1: a=4'hF, b=4'h1, cin=0 -> after 1 clk edge sum=4'h0, cout=1, ovf=0; before that edge, outputs SHALL still be the prior values.
REQ-032 WIDTH=4, REGISTERED=1: a=4'h7, b=4'h1, cin=0 -> sum=4'h8, cout=0, ovf=1.
REQ-033 WIDTH=4, REGISTERED=1: rst=1 during one edge with a=4'hF, b=4'hF, cin=1 -> sum=0, cout=0, ovf=0; after rst deasserts, next edge -> sum=4'hF, cout=1.
REQ-034 WIDTH=8, REGISTERED=0: random a, b, cin for 1000 vectors -> {cout,sum} SHALL equal the reference a+b+cin.
